// File: rtl/mio_pkg.sv
// Shared types and constants for the CPU memory/IO responder.
//   state_e        : responder FSM states
//   target_e       : decoded access target
//   decode_region  : maps addr[31:28] to a target
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TGT_RAM    = 2'd0,
    TGT_PERIPH = 2'd1,
    TGT_NONE   = 2'd2
  } target_e;

  localparam logic [3:0] REGION_RAM    = 4'h0;
  localparam logic [3:0] REGION_PERIPH = 4'hF;

  localparam logic [1:0] OFF_SWLED   = 2'b00;
  localparam logic [1:0] OFF_COUNTER = 2'b01;

  // Top address nibble selects the target; everything else is unmapped.
  function automatic target_e decode_region(input logic [3:0] region);
    target_e tgt;
    case (region)
      REGION_RAM:    tgt = TGT_RAM;
      REGION_PERIPH: tgt = TGT_PERIPH;
      default:       tgt = TGT_NONE;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/mio_cycle_counter.sv
// Free-running 32-bit cycle counter; a load overrides that cycle's increment.
//   clk, reset   : clock, async active-low reset (count clears to 0)
//   load         : load load_val instead of incrementing
//   load_val     : value to load
//   count_nxt_c  : combinational value the counter takes at the next edge
module mio_cycle_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] count_nxt_c
);

  logic [31:0] count_q;

  // Wraps naturally from 0xFFFF_FFFF to 0.
  assign count_nxt_c = load ? load_val : count_q + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= 32'd0;
    else        count_q <= count_nxt_c;
  end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder at the slave end of the CPU memory interface.
//   clk, reset            : clock, async active-low reset
//   mem_req/mem_w         : request valid / write select (held until mio_ready)
//   addr_bus              : byte address, [31:28] region, [3:2] peripheral offset
//   data_from_cpu         : write data
//   data2cpu, mio_ready   : registered read data, one-cycle completion pulse
//   ram_addr/ram_din/ram_we/ram_dout : external synchronous RAM port
//   sw_in, led_out        : switch inputs, LED register
module mio_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned LED_W   = 8,
  parameter int unsigned SW_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       data_from_cpu,
  output logic [31:0]       data2cpu,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out
);

  localparam int unsigned WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RAM_LAT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              lat_w_q;

  target_e           target_c;
  logic [1:0]        offset_c;
  logic              accept_c;
  logic              cnt_load_c;
  logic              led_we_c;
  logic [31:0]       cnt_nxt_c;
  logic [31:0]       rd_data_c;
  logic              unused_addr_c;

  assign target_c      = decode_region(addr_bus[31:28]);
  assign offset_c      = addr_bus[3:2];
  assign accept_c      = (state_q == IDLE) && mem_req;
  assign cnt_load_c    = accept_c && mem_w && (target_c == TGT_PERIPH) && (offset_c == OFF_COUNTER);
  assign led_we_c      = accept_c && mem_w && (target_c == TGT_PERIPH) && (offset_c == OFF_SWLED);
  assign unused_addr_c = ^addr_bus;

  // Counter reads return the value in effect from the accepting edge onward.
  always_comb begin
    rd_data_c = 32'd0;
    if (target_c == TGT_PERIPH) begin
      case (offset_c)
        OFF_SWLED:   rd_data_c = 32'(sw_in);
        OFF_COUNTER: rd_data_c = cnt_nxt_c;
        default:     rd_data_c = 32'd0;
      endcase
    end
  end

  mio_cycle_counter u_counter (
    .clk         (clk),
    .reset       (reset),
    .load        (cnt_load_c),
    .load_val    (data_from_cpu),
    .count_nxt_c (cnt_nxt_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; RELEASE blocks re-servicing a still-held request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req) state_d = (target_c == TGT_RAM) ? ACCESS : RESP;
      ACCESS:  if (wait_q == '0) state_d = RESP;
      RESP:    state_d = RELEASE;
      RELEASE: if (!mem_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, RAM port, peripheral registers and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q    <= '0;
      lat_w_q   <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= 32'd0;
      ram_we    <= 1'b0;
      mio_ready <= 1'b0;
      data2cpu  <= 32'd0;
      led_out   <= '0;
    end else begin
      ram_we    <= 1'b0;
      mio_ready <= (state_d == RESP);
      if (led_we_c) led_out <= data_from_cpu[LED_W-1:0];
      if (accept_c) begin
        lat_w_q <= mem_w;
        if (target_c == TGT_RAM) begin
          ram_addr <= addr_bus[RAM_AW+1:2];
          ram_din  <= data_from_cpu;
          ram_we   <= mem_w;
          wait_q   <= WAIT_INIT;
        end else if (!mem_w) begin
          data2cpu <= rd_data_c;
        end
      end
      if (state_q == ACCESS) begin
        if (wait_q != '0)  wait_q   <= wait_q - WAIT_W'(1);
        else if (!lat_w_q) data2cpu <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Directed self-checking bench for mio_responder with a synchronous RAM model.
module tb_mio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] data_from_cpu;
  logic [31:0] data2cpu;
  logic        mio_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int rdy_cnt = 0;
  logic [9:0]  we_addr;
  logic [31:0] we_din;
  logic [7:0]  led_e0;

  logic [31:0] ram_mem [0:1023];

  mio_responder #(.RAM_AW(10), .RAM_LAT(2), .LED_W(8), .SW_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_w         (mem_w),
    .addr_bus      (addr_bus),
    .data_from_cpu (data_from_cpu),
    .data2cpu      (data2cpu),
    .mio_ready     (mio_ready),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_we        (ram_we),
    .ram_dout      (ram_dout),
    .sw_in         (sw_in),
    .led_out       (led_out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one register stage; word 4 preset while reset is low.
  always @(posedge clk) begin
    if (!reset) ram_mem[4] <= 32'hDEAD_BEEF;
    else if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  // Pulse monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
      we_din  <= ram_din;
    end
    if (mio_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full handshake; lat = cycles from E0 to the ready cycle (0 = timeout).
  // Request fields are scrambled after E0 to prove only latched values matter.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    mem_req = 1'b1; mem_w = w; addr_bus = a; data_from_cpu = d;
    tick();
    led_e0 = led_out;
    mem_w = ~w; addr_bus = 32'hF000_0004; data_from_cpu = 32'h0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (mio_ready === 1'b1) begin
        lat = i;
        break;
      end
      tick();
    end
    rd = data2cpu;
    mem_req = 1'b0; mem_w = 1'b0; addr_bus = 32'h0;
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    int lat, we0, rdy0, hold_lat;

    reset = 1'b0; mem_req = 1'b0; mem_w = 1'b0; addr_bus = 32'h0;
    data_from_cpu = 32'h0; sw_in = 8'h00;
    tick(); tick();
    chk("rst_data2cpu", data2cpu, 32'h0);
    chk("rst_ready", 32'(mio_ready), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    reset = 1'b1;
    tick();

    // RAM read of word 4
    do_req(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    chk("ram_rd_lat", 32'(lat), 32'd3);
    chk("ram_rd_data", rd, 32'hDEAD_BEEF);
    chk("ram_rd_addr", 32'(ram_addr), 32'd4);

    // RAM write of word 8, then read back
    we0 = we_cnt;
    do_req(1'b1, 32'h0000_0020, 32'h1234_5678, rd, lat);
    chk("ram_wr_lat", 32'(lat), 32'd3);
    chk("ram_wr_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("ram_wr_addr", 32'(we_addr), 32'd8);
    chk("ram_wr_din", we_din, 32'h1234_5678);
    chk("ram_wr_keeps_data2cpu", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0020, 32'h0, rd, lat);
    chk("ram_rb_lat", 32'(lat), 32'd3);
    chk("ram_rb_data", rd, 32'h1234_5678);

    // LED write (upper data bits dropped) and switch read
    do_req(1'b1, 32'hF000_0000, 32'hFFFF_FFA5, rd, lat);
    chk("led_wr_lat", 32'(lat), 32'd1);
    chk("led_at_e0", 32'(led_e0), 32'hA5);
    sw_in = 8'h3C;
    do_req(1'b0, 32'hF000_0000, 32'h0, rd, lat);
    chk("sw_rd_lat", 32'(lat), 32'd1);
    chk("sw_rd_data", rd, 32'h0000_003C);
    chk("led_hold", 32'(led_out), 32'hA5);

    // Counter: load then read 3 edges later, with wrap through zero
    do_req(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat);
    chk("cnt_wr_lat", 32'(lat), 32'd1);
    do_req(1'b0, 32'hF000_0004, 32'h0, rd, lat);
    chk("cnt_rd_lat", 32'(lat), 32'd1);
    chk("cnt_wrap", rd, 32'h0000_0001);
    do_req(1'b1, 32'hF000_0004, 32'h0000_0007, rd, lat);
    repeat (5) tick();
    do_req(1'b0, 32'hF000_0004, 32'h0, rd, lat);
    chk("cnt_idle_gap", rd, 32'h0000_000F);

    // Request held high long after ready: single service only
    we0 = we_cnt; rdy0 = rdy_cnt; hold_lat = 0;
    mem_req = 1'b1; mem_w = 1'b1; addr_bus = 32'h0000_0030; data_from_cpu = 32'hCAFE_F00D;
    tick();
    for (int i = 1; i <= 20; i++) begin
      if (mio_ready === 1'b1) begin
        hold_lat = i;
        break;
      end
      tick();
    end
    chk("hold_lat", 32'(hold_lat), 32'd3);
    repeat (10) tick();
    chk("hold_one_ready", 32'(rdy_cnt - rdy0), 32'd1);
    chk("hold_one_we", 32'(we_cnt - we0), 32'd1);
    mem_req = 1'b0; mem_w = 1'b0; addr_bus = 32'h0;
    tick();
    do_req(1'b0, 32'hF000_0000, 32'h0, rd, lat);
    chk("post_hold_lat", 32'(lat), 32'd1);
    chk("post_hold_sw", rd, 32'h0000_003C);
    do_req(1'b0, 32'h0000_0030, 32'h0, rd, lat);
    chk("hold_rb_data", rd, 32'hCAFE_F00D);

    // Reset during ACCESS of a RAM read aborts it
    rdy0 = rdy_cnt;
    mem_req = 1'b1; mem_w = 1'b0; addr_bus = 32'h0000_0010;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_data2cpu", data2cpu, 32'h0);
    chk("abort_led", 32'(led_out), 32'h0);
    tick(); tick();
    mem_req = 1'b0; addr_bus = 32'h0;
    reset = 1'b1;
    repeat (4) tick();
    chk("abort_no_ready", 32'(rdy_cnt - rdy0), 32'd0);
    chk("abort_data_held", data2cpu, 32'h0);
    do_req(1'b0, 32'h0000_0020, 32'h0, rd, lat);
    chk("after_rst_lat", 32'(lat), 32'd3);
    chk("after_rst_data", rd, 32'h1234_5678);

    // Unmapped accesses
    do_req(1'b0, 32'h5000_0000, 32'h0, rd, lat);
    chk("unmapped_rd_lat", 32'(lat), 32'd1);
    chk("unmapped_rd_data", rd, 32'h0);
    do_req(1'b1, 32'h5000_0000, 32'hFFFF_FFFF, rd, lat);
    chk("unmapped_wr_lat", 32'(lat), 32'd1);
    chk("unmapped_wr_led", 32'(led_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
Name: mio_responder

Overview:
- Memory/IO responder at the slave end of the CPU memory interface.
- Accepts word requests from the multicycle CPU data path: address, write data and write strobe, held under a request line.
- Services each request from an external synchronous RAM or from on-chip peripheral registers: LED output, switch input, free-running cycle counter.
- Returns read data plus a one-cycle ready pulse, so the CPU FSM can stall on slow accesses.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM holds 2^RAM_AW words).
- RAM_LAT, 2, RAM read latency in cycles from address presented to ram_dout valid; must be ≥1.
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  input  1  CPU request valid; held until mio_ready is seen.
- mem_w  input  1  1 = write, 0 = read; valid with mem_req.
- addr_bus  input  32  CPU byte address; bits [1:0] ignored.
- data_from_cpu  input  32  write data.
- data2cpu  output  32  registered read data.
- mio_ready  output  1  one-cycle completion pulse.
- ram_addr  output  RAM_AW  RAM word address, equal to latched addr[RAM_AW+1:2].
- ram_din  output  32  RAM write data.
- ram_we  output  1  RAM write enable, one-cycle pulse.
- ram_dout  input  32  RAM read data.
- sw_in  input  SW_W  switch inputs (already synchronised externally).
- led_out  output  LED_W  LED register.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - mio_ready=0, ram_we=0.
  - data2cpu, led_out, counter, ram_addr and ram_din all clear to 0.
  - Reset mid-access aborts the access: no ready pulse, no further RAM write.
- Address map (addr_bus[31:28]):
  - 0x0: RAM.
  - 0xF: peripherals, decoded on addr[3:2]. 00 = SW/LED (read returns zero-extended sw_in; write sets led_out = data_from_cpu[LED_W-1:0]). 01 = counter (read returns counter value; write loads it).
  - All other addresses: read returns 0, write ignored, ready still pulses.
- FSM states:
  - IDLE: on mem_req=1 at edge E0, latch addr, data and mem_w. RAM target goes to ACCESS with wait counter = RAM_LAT-1. Any other target goes to RESP.
  - ACCESS: ram_addr and ram_din are driven from the latches. For a write, ram_we=1 only in the first ACCESS cycle. Counter decrements each cycle. When counter=0, capture ram_dout into data2cpu (reads only) and go to RESP.
  - RESP: mio_ready=1 for exactly this cycle. Next state is RELEASE.
  - RELEASE: wait for mem_req=0, then go to IDLE. This blocks re-servicing a still-held request.
- Timing:
  - Peripheral or unmapped access: mio_ready is high in the cycle after E0 (latency 1).
  - RAM access: mio_ready is high RAM_LAT+1 cycles after E0.
  - Peripheral writes and reads take effect at E0. data2cpu is valid in the RESP cycle.
- data2cpu holds its value until the next read completes. Writes never modify data2cpu.
- Counter:
  - 32-bit, increments every cycle in all states.
  - Wraps 0xFFFF_FFFF → 0.
  - A CPU write in the same cycle overrides the increment; the next cycle continues from written value + 1.
- mem_w and addr_bus changing after E0 have no effect. Only latched values are used.
- mem_req dropping before mio_ready is a protocol violation. The access completes anyway, and the responder returns to IDLE after RESP because RELEASE sees mem_req=0.

Decomposition:
- Package mio_pkg:
  - FSM state enum: IDLE, ACCESS, RESP, RELEASE.
  - Region constants: REGION_RAM=4'h0, REGION_PERIPH=4'hF.
  - Peripheral offsets: OFF_SWLED=2'b00, OFF_COUNTER=2'b01.
  - Region-decode function.
- Sub-module mio_cycle_counter holds the 32-bit counter with load-overrides-increment. Everything else is flat.

Test Plan:
- Reset release, then RAM read at 0x0000_0010 with RAM_LAT=2 and the RAM model returning 0xDEAD_BEEF at word 4 → ram_addr=4, mio_ready pulses exactly 3 cycles after E0, data2cpu=0xDEAD_BEEF.
- RAM write of 0x1234_5678 to 0x0000_0020 → ram_we high for one cycle with ram_addr=8 and ram_din=0x1234_5678; ready at E0+3; a following read of the same address returns 0x1234_5678.
- Write 0xA5 to 0xF000_0000, then read it with sw_in=0x3C → led_out=0xA5 one cycle after E0; read returns 0x0000_003C with ready at E0+1.
- Write 0xFFFF_FFFE to the counter at 0xF000_0004, then read 3 cycles after that write → counter wraps through 0; read returns 0x0000_0001 (written value + 3 mod 2^32); a write coinciding with an increment loads the exact written value.
- mem_req held high for 10 cycles after ready → exactly one mio_ready pulse and no second RAM access; IDLE is re-entered only after mem_req=0.
- Assert reset during ACCESS of a RAM read → mio_ready never pulses; data2cpu=0; after release a new request completes normally; read of unmapped 0x5000_0000 returns 0 with ready at E0+1.
